// File: rtl/led_pattern_gen.sv
// led_pattern_gen
//
// Drives an N-wide LED bank with one of four animated patterns, advancing one
// pattern step every STEP enabled cycles of divided_clock.
//
//   BOUNCE (0): a W-wide lit window moves up to the top end, then back down.
//   ROTATE (1): a W-wide lit window circulates; dir picks the direction.
//   FILL   (2): the bar graph grows from 0 to N lit LEDs, then clears.
//   BLINK  (3): all LEDs toggle between on and off.
//
// Ports
//   divided_clock  in   pattern clock, all state updates on its rising edge
//   rst            in   asynchronous active-high reset
//   en             in   step enable; low freezes all state
//   mode[1:0]      in   requested pattern
//   dir            in   ROTATE direction: 1 toward MSB, 0 toward LSB
//   outLED[N-1:0]  out  registered LED pattern
//   active_mode    out  registered pattern currently in effect
//   cycle_done     out  one-cycle pulse on the step that completes a pattern period
//
// A mode change only takes effect on a step edge. That edge loads the new
// pattern's start state and applies no pattern step.

module led_pattern_gen #(
  parameter int unsigned N    = 8,
  parameter int unsigned W    = 1,
  parameter int unsigned STEP = 1
) (
  input  logic         divided_clock,
  input  logic         rst,
  input  logic         en,
  input  logic [1:0]   mode,
  input  logic         dir,
  output logic [N-1:0] outLED,
  output logic [1:0]   active_mode,
  output logic         cycle_done
);

  // Position/count must reach N itself (FILL count), hence N+1 codes.
  localparam int unsigned PW = $clog2(N + 1);
  localparam int unsigned TW = (STEP > 1) ? $clog2(STEP) : 1;

  localparam logic [TW-1:0] TickLast  = TW'(STEP - 1);
  localparam logic [PW-1:0] PosZero   = '0;
  localparam logic [PW-1:0] PosOne    = PW'(1);
  localparam logic [PW-1:0] PosLast   = PW'(N - 1);
  localparam logic [PW-1:0] BounceTop = PW'(N - W);
  localparam logic [PW-1:0] FillFull  = PW'(N);
  localparam logic [N-1:0]  AllOnes   = {N{1'b1}};

  typedef enum logic [1:0] {
    ModeBounce = 2'd0,
    ModeRotate = 2'd1,
    ModeFill   = 2'd2,
    ModeBlink  = 2'd3
  } mode_e;

  // W-wide window starting at bit p, wrapping past the MSB back to bit 0.
  // BOUNCE never lets the window reach the MSB boundary, so the same helper
  // serves both window patterns.
  function automatic logic [N-1:0] win_at(input logic [PW-1:0] p);
    logic [N-1:0]   base;
    logic [2*N-1:0] dbl;
    for (int unsigned k = 0; k < N; k++) begin
      base[k] = (k < W);
    end
    dbl = {base, base} << p;
    return dbl[2*N-1:N];
  endfunction

  // Lower c bits set.
  function automatic logic [N-1:0] low_ones(input logic [PW-1:0] c);
    logic [N-1:0] r;
    for (int unsigned k = 0; k < N; k++) begin
      r[k] = (PW'(k) < c);
    end
    return r;
  endfunction

  localparam logic [N-1:0] LedReset = win_at(PosZero);

  logic [TW-1:0] tick_q, tick_d;
  logic [PW-1:0] pos_q,  pos_d;   // BOUNCE / ROTATE window position
  logic [PW-1:0] cnt_q,  cnt_d;   // FILL lit count
  logic          up_q,   up_d;    // BOUNCE direction, 1 = toward MSB
  logic [1:0]    mode_q, mode_d;
  logic [N-1:0]  led_q,  led_d;
  logic          done_q, done_d;
  logic          step_edge;

  always_comb begin
    tick_d    = tick_q;
    pos_d     = pos_q;
    cnt_d     = cnt_q;
    up_d      = up_q;
    mode_d    = mode_q;
    led_d     = led_q;
    done_d    = 1'b0;
    step_edge = 1'b0;

    if (en) begin
      if (tick_q == TickLast) begin
        tick_d    = '0;
        step_edge = 1'b1;
      end else begin
        tick_d = tick_q + TW'(1);
      end
    end

    if (step_edge) begin
      if (mode != mode_q) begin
        // Switch pattern: load its start state, no step this edge.
        mode_d = mode;
        pos_d  = PosZero;
        cnt_d  = PosZero;
        up_d   = 1'b1;
        unique case (mode_e'(mode))
          ModeBounce: led_d = win_at(PosZero);
          ModeRotate: led_d = win_at(PosZero);
          ModeFill:   led_d = '0;
          ModeBlink:  led_d = AllOnes;
        endcase
      end else begin
        unique case (mode_e'(mode_q))
          ModeBounce: begin
            if (W == N) begin
              // Window fills the bank: nothing moves, every step ends a period.
              led_d  = AllOnes;
              done_d = 1'b1;
            end else if (up_q) begin
              pos_d = pos_q + PosOne;
              // Reverse on arrival so the next step already heads back.
              if (pos_d == BounceTop) begin
                up_d = 1'b0;
              end
              led_d = win_at(pos_d);
            end else begin
              pos_d = pos_q - PosOne;
              if (pos_d == PosZero) begin
                up_d   = 1'b1;
                done_d = 1'b1;
              end
              led_d = win_at(pos_d);
            end
          end
          ModeRotate: begin
            if (dir) begin
              pos_d = (pos_q == PosLast) ? PosZero : pos_q + PosOne;
            end else begin
              pos_d = (pos_q == PosZero) ? PosLast : pos_q - PosOne;
            end
            done_d = (pos_d == PosZero);
            led_d  = win_at(pos_d);
          end
          ModeFill: begin
            cnt_d  = (cnt_q == FillFull) ? PosZero : cnt_q + PosOne;
            done_d = (cnt_d == PosZero);
            led_d  = low_ones(cnt_d);
          end
          ModeBlink: begin
            if (led_q == AllOnes) begin
              led_d = '0;
            end else begin
              led_d  = AllOnes;
              done_d = 1'b1;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge divided_clock or posedge rst) begin
    if (rst) begin
      tick_q <= '0;
      pos_q  <= PosZero;
      cnt_q  <= PosZero;
      up_q   <= 1'b1;
      mode_q <= 2'd0;
      led_q  <= LedReset;
      done_q <= 1'b0;
    end else begin
      tick_q <= tick_d;
      pos_q  <= pos_d;
      cnt_q  <= cnt_d;
      up_q   <= up_d;
      mode_q <= mode_d;
      led_q  <= led_d;
      done_q <= done_d;
    end
  end

  assign outLED      = led_q;
  assign active_mode = mode_q;
  assign cycle_done  = done_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Randomised bench for led_pattern_gen: three instances with different
// N/W/STEP share one stimulus stream and are each compared every cycle
// against a behavioural model of the pattern rules.

module tb_led_pattern_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic       dir;

  logic [7:0] led_a, led_b;
  logic [3:0] led_c;
  logic [1:0] am_a, am_b, am_c;
  logic       done_a, done_b, done_c;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  led_pattern_gen #(.N(8), .W(1), .STEP(1)) dut_a (
    .divided_clock(clk), .rst(rst), .en(en), .mode(mode), .dir(dir),
    .outLED(led_a), .active_mode(am_a), .cycle_done(done_a)
  );

  led_pattern_gen #(.N(8), .W(3), .STEP(3)) dut_b (
    .divided_clock(clk), .rst(rst), .en(en), .mode(mode), .dir(dir),
    .outLED(led_b), .active_mode(am_b), .cycle_done(done_b)
  );

  led_pattern_gen #(.N(4), .W(4), .STEP(2)) dut_c (
    .divided_clock(clk), .rst(rst), .en(en), .mode(mode), .dir(dir),
    .outLED(led_c), .active_mode(am_c), .cycle_done(done_c)
  );

  int cfg_n[3] = '{8, 8, 4};
  int cfg_w[3] = '{1, 3, 4};
  int cfg_s[3] = '{1, 3, 2};

  // BOUNCE is tracked as a phase t within its 2*(N-W)-step period; ROTATE as a
  // position; FILL as a count; BLINK as a phase (0 = all on).
  typedef struct {
    int         am;
    int         t;
    int         rpos;
    int         c;
    int         bph;
    int         tick;
    logic [7:0] led;
    bit         done;
  } mdl_t;

  mdl_t m[3];

  function automatic logic [7:0] win(int n, int w, int p);
    logic [7:0] r;
    r = '0;
    for (int k = 0; k < w; k++) r[(p + k) % n] = 1'b1;
    return r;
  endfunction

  function automatic logic [7:0] led_of(mdl_t s, int n, int w);
    logic [7:0] r;
    int         p;
    r = '0;
    case (s.am)
      0: begin
        p = (s.t <= n - w) ? s.t : 2 * (n - w) - s.t;
        r = win(n, w, p);
      end
      1: r = win(n, w, s.rpos);
      2: for (int k = 0; k < s.c; k++) r[k] = 1'b1;
      default: if (s.bph == 0) for (int k = 0; k < n; k++) r[k] = 1'b1;
    endcase
    return r;
  endfunction

  function automatic mdl_t mdl_reset(int n, int w);
    mdl_t s;
    s.am = 0; s.t = 0; s.rpos = 0; s.c = 0; s.bph = 0; s.tick = 0;
    s.done = 1'b0;
    s.led = win(n, w, 0);
    return s;
  endfunction

  function automatic mdl_t mdl_edge(mdl_t s0, int n, int w, int st, bit e, int md, bit d);
    mdl_t s;
    int   per;
    s = s0;
    s.done = 1'b0;
    if (!e) return s;
    s.tick++;
    if (s.tick < st) return s;
    s.tick = 0;
    if (md != s.am) begin
      s.am = md; s.t = 0; s.rpos = 0; s.c = 0; s.bph = 0;
      s.led = led_of(s, n, w);
      return s;
    end
    case (s.am)
      0: begin
        per = 2 * (n - w);
        if (per == 0) s.done = 1'b1;
        else begin
          s.t = (s.t + 1) % per;
          s.done = (s.t == 0);
        end
      end
      1: begin
        s.rpos = d ? (s.rpos + 1) % n : (s.rpos + n - 1) % n;
        s.done = (s.rpos == 0);
      end
      2: begin
        s.c = (s.c + 1) % (n + 1);
        s.done = (s.c == 0);
      end
      default: begin
        s.bph = 1 - s.bph;
        s.done = (s.bph == 0);
      end
    endcase
    s.led = led_of(s, n, w);
    return s;
  endfunction

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic check_all(string ph);
    check_eq({ph, " a.led"},  32'(led_a),  32'(m[0].led));
    check_eq({ph, " a.mode"}, 32'(am_a),   32'(m[0].am));
    check_eq({ph, " a.done"}, 32'(done_a), 32'(m[0].done));
    check_eq({ph, " b.led"},  32'(led_b),  32'(m[1].led));
    check_eq({ph, " b.mode"}, 32'(am_b),   32'(m[1].am));
    check_eq({ph, " b.done"}, 32'(done_b), 32'(m[1].done));
    check_eq({ph, " c.led"},  32'(led_c),  32'(m[2].led[3:0]));
    check_eq({ph, " c.mode"}, 32'(am_c),   32'(m[2].am));
    check_eq({ph, " c.done"}, 32'(done_c), 32'(m[2].done));
  endtask

  task automatic reset_models();
    for (int i = 0; i < 3; i++) m[i] = mdl_reset(cfg_n[i], cfg_w[i]);
  endtask

  // Called at a falling edge: reset asserts between clock edges and must
  // show up before the next rising edge.
  task automatic pulse_reset();
    #2 rst = 1'b1;
    #1;
    reset_models();
    check_all("async_rst");
    @(negedge clk);
    check_all("rst_hold");
    rst = 1'b0;
  endtask

  initial begin
    rst  = 1'b1;
    en   = 1'b0;
    mode = 2'd0;
    dir  = 1'b1;
    reset_models();
    @(negedge clk);
    check_all("reset");
    rst = 1'b0;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc == 150 || (cyc >= 160 && $urandom_range(59) == 0)) begin
        pulse_reset();
      end else begin
        if (cyc < 160) begin
          // Directed warm-up: each mode in turn with en held high.
          en   = 1'b1;
          mode = 2'(cyc / 40);
          dir  = (cyc >= 60 && cyc < 80) ? 1'b0 : 1'b1;
        end else begin
          en = ($urandom_range(99) < 85);
          if ($urandom_range(29) == 0) mode = 2'($urandom_range(3));
          if ($urandom_range(9) == 0) dir = ~dir;
        end
        for (int i = 0; i < 3; i++) begin
          m[i] = mdl_edge(m[i], cfg_n[i], cfg_w[i], cfg_s[i], en, int'(mode), dir);
        end
        @(negedge clk);
        check_all("run");
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/led_pattern_gen.md
LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

Interface
REQ-001 Parameter N, default 8, meaning number of LEDs; legal range N >= 2.
REQ-002 Parameter W, default 1, meaning lit-window width; legal range 1 <= W <= N.
REQ-003 Parameter STEP, default 1, meaning enabled divided_clock cycles per pattern step; legal range STEP >= 1.
REQ-004 Port divided_clock  input  1  pattern clock; all state updates on its rising edge.
REQ-005 Port rst  input  1  reset, asynchronous, active-high.
REQ-006 Port en  input  1  step enable; low freezes all state.
REQ-007 Port mode  input  2  requested pattern: 0 BOUNCE, 1 ROTATE, 2 FILL, 3 BLINK.
REQ-008 Port dir  input  1  ROTATE direction: 1 toward MSB, 0 toward LSB.
REQ-009 Port outLED  output  N  registered LED pattern.
REQ-010 Port active_mode  output  2  registered mode currently in effect.
REQ-011 Port cycle_done  output  1  registered one-cycle pulse at pattern-period completion.

Function
REQ-012 Internal tick counter SHALL count 0..STEP-1 while en=1; a step edge is an edge with en=1 and counter = STEP-1; the counter then returns to 0.
REQ-013 While en=0, tick counter, position, direction, active_mode and outLED SHALL hold; cycle_done SHALL be 0.
REQ-014 outLED SHALL change only on step edges; latency from step edge to new outLED is that same edge (no extra cycle).
REQ-015 On a step edge with mode != active_mode: active_mode <= mode, load the new mode's start state, cycle_done=0, no step applied.
REQ-016 BOUNCE: lit bits pos..pos+W-1; start pos=0, direction up; up: pos+1 until pos=N-W, then reverse; down: pos-1 until pos=0, then reverse (reversal at an end is taken in the same step, no dwell).
REQ-017 BOUNCE with W=N: outLED static all-ones; cycle_done asserted on every step.
REQ-018 BOUNCE cycle_done SHALL pulse on the step that moves pos to 0; period 2*(N-W) steps.
REQ-019 ROTATE: lit bits (pos+k) mod N for k=0..W-1; start pos=0; dir=1: pos+1 wrapping N-1 -> 0; dir=0: pos-1 wrapping 0 -> N-1.
REQ-020 ROTATE: dir sampled at each step edge; changes take effect on that step; cycle_done pulses on the step landing pos at 0.
REQ-021 FILL: count c in 0..N, outLED = lower c bits set; start c=0; each step c+1, N wraps to 0; cycle_done pulses on the wrap N -> 0.
REQ-022 BLINK: start all-ones; each step toggles between all-ones and all-zeros; cycle_done pulses on each return to all-ones.
REQ-023 cycle_done SHALL be high for exactly one divided_clock cycle per qualifying step and 0 otherwise.
REQ-024 Position and count arithmetic SHALL be sized to hold 0..N without overflow for any legal N; the tick counter to hold 0..STEP-1 (minimum 1 bit).

Reset
REQ-025 On rst=1, immediately and independent of divided_clock: active_mode=0, pos=0, direction up, c=0, tick counter=0, outLED = W ones at LSB, cycle_done=0.
REQ-026 rst asserted mid-pattern or mid-count SHALL abort the pattern; after release the first step occurs on the STEP-th enabled edge.
REQ-027 mode is not applied at reset; a non-zero mode held through reset SHALL be loaded at the first step edge per REQ-015.

Verification (N=8 unless stated)
REQ-028 W=1, STEP=1, mode=0, en=1: from reset 01,02,04,...,80,40,...,01; cycle_done only on the 14th step.
REQ-029 W=3, STEP=1, mode=1, dir=1: first edge loads start 07; then 0E,...,E0,C1,83,07; cycle_done on the step yielding 07; switch dir=0 at 83 -> next C1.
REQ-030 W=1, STEP=1, mode=2: first edge loads 00, then 01,03,07,...,FF,00; cycle_done on FF -> 00 only.
REQ-031 W=1, STEP=4, mode=0: outLED changes every 4th edge; en=0 for 10 cycles after count 2 -> no change; resumes after exactly 2 more enabled edges.
REQ-032 W=1, STEP=1, mode=3 then mode=0 while BLINK at 00: next step loads 01, no cycle_done; rst pulse between clock edges at outLED=20 -> outLED=01, active_mode=0 immediately.
